// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: decode, writeback and issue-lane signals of the dual-issue scheduler
interface issue_scheduler_if #(
  parameter int NREGS = 32
);
  logic [1:0] in_valid;
  logic [5:0] in_op0, in_op1, in_func0, in_func1;
  logic [4:0] in_src1_0, in_src1_1, in_src2_0, in_src2_1, in_dest0, in_dest1;
  logic [15:0] in_imm0, in_imm1;
  logic [1:0] in_accept;
  logic ex_stall, flush;
  logic [1:0] wb_valid;
  logic [4:0] wb_reg0, wb_reg1;
  logic [1:0] iss_valid;
  logic [5:0] iss_op0, iss_op1, iss_func0, iss_func1;
  logic [4:0] iss_src1_0, iss_src1_1, iss_src2_0, iss_src2_1, iss_dest0, iss_dest1;
  logic [15:0] iss_imm0, iss_imm1;
  logic [NREGS-1:0] busy;
  modport master (
    output in_valid, in_op0, in_op1, in_func0, in_func1, in_src1_0, in_src1_1,
           in_src2_0, in_src2_1, in_dest0, in_dest1, in_imm0, in_imm1,
           ex_stall, flush, wb_valid, wb_reg0, wb_reg1,
    input  in_accept, iss_valid, iss_op0, iss_op1, iss_func0, iss_func1,
           iss_src1_0, iss_src1_1, iss_src2_0, iss_src2_1, iss_dest0, iss_dest1,
           iss_imm0, iss_imm1, busy
  );
  modport slave (
    input  in_valid, in_op0, in_op1, in_func0, in_func1, in_src1_0, in_src1_1,
           in_src2_0, in_src2_1, in_dest0, in_dest1, in_imm0, in_imm1,
           ex_stall, flush, wb_valid, wb_reg0, wb_reg1,
    output in_accept, iss_valid, iss_op0, iss_op1, iss_func0, iss_func1,
           iss_src1_0, iss_src1_1, iss_src2_0, iss_src2_1, iss_dest0, iss_dest1,
           iss_imm0, iss_imm1, busy
  );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue in-order scheduler with a register scoreboard
module issue_scheduler #(
  parameter int NREGS = 32
) (
  input logic clk,
  input logic rst_n,
  issue_scheduler_if.slave b
);
  // class bits: {legal, branch, reads src1, reads src2, writes dest, memory}
  function automatic logic [5:0] cls(input logic [5:0] op);
    case (op)
      6'h00: cls = 6'b101110;
      6'h23: cls = 6'b101011;
      6'h08: cls = 6'b101010;
      6'h2b: cls = 6'b101101;
      6'h04, 6'h05: cls = 6'b111100;
      default: cls = 6'b000000;
    endcase
  endfunction
  logic [5:0] c0, c1, k0, k1;
  logic w0, w1, blk0, blk1, raw, waw, acc0, acc1;
  logic [NREGS-1:0] busy_n;
  assign c0 = cls(b.in_op0);
  assign c1 = cls(b.in_op1);
  assign k0 = cls(b.iss_op0);
  assign k1 = cls(b.iss_op1);
  assign w0 = c0[1] && b.in_dest0 != 5'd0;
  assign w1 = c1[1] && b.in_dest1 != 5'd0;
  assign blk0 = (c0[3] && b.busy[b.in_src1_0]) || (c0[2] && b.busy[b.in_src2_0]);
  assign blk1 = (c1[3] && b.busy[b.in_src1_1]) || (c1[2] && b.busy[b.in_src2_1]);
  assign raw = w0 && ((c1[3] && b.in_src1_1 == b.in_dest0) || (c1[2] && b.in_src2_1 == b.in_dest0));
  assign waw = w0 && w1 && b.in_dest0 == b.in_dest1;
  assign acc0 = rst_n && b.in_valid[0] && !b.ex_stall && !b.flush && !blk0;
  assign acc1 = acc0 && b.in_valid[1] && c1[5] && !blk1 && !raw && !waw &&
                !(c0[0] && c1[0]) && c0[5] && !c0[4];
  assign b.in_accept = {acc1, acc0};
  // clears first (writeback, then flushed lanes), sets last so a new issue wins
  always_comb begin
    busy_n = b.busy;
    if (b.wb_valid[0]) busy_n[b.wb_reg0] = 1'b0;
    if (b.wb_valid[1]) busy_n[b.wb_reg1] = 1'b0;
    if (b.flush && b.iss_valid[0] && k0[1]) busy_n[b.iss_dest0] = 1'b0;
    if (b.flush && b.iss_valid[1] && k1[1]) busy_n[b.iss_dest1] = 1'b0;
    if (acc0 && w0) busy_n[b.in_dest0] = 1'b1;
    if (acc1 && w1) busy_n[b.in_dest1] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b.busy <= '0;
      b.iss_valid <= '0;
      {b.iss_op0, b.iss_func0, b.iss_src1_0, b.iss_src2_0, b.iss_dest0, b.iss_imm0} <= '0;
      {b.iss_op1, b.iss_func1, b.iss_src1_1, b.iss_src2_1, b.iss_dest1, b.iss_imm1} <= '0;
    end else begin
      b.busy <= busy_n;
      if (b.flush) begin
        b.iss_valid <= '0;
      end else if (!b.ex_stall) begin
        b.iss_valid <= {acc1, acc0};
        {b.iss_op0, b.iss_func0, b.iss_src1_0, b.iss_src2_0, b.iss_dest0, b.iss_imm0} <=
          {b.in_op0, b.in_func0, b.in_src1_0, b.in_src2_0, b.in_dest0, b.in_imm0};
        {b.iss_op1, b.iss_func1, b.iss_src1_1, b.iss_src2_1, b.iss_dest1, b.iss_imm1} <=
          {b.in_op1, b.in_func1, b.in_src1_1, b.in_src2_1, b.in_dest1, b.in_imm1};
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed plus randomized checks against a rule-level scoreboard model
module tb_issue_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_scheduler_if #(.NREGS(32)) ifc ();
  issue_scheduler #(.NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .b(ifc));

  logic [1:0] vin = 2'b11;
  logic stall = 1'b0, fl = 1'b0;
  logic [1:0] wbv = 2'b00;
  logic [4:0] wr0 = 5'd0, wr1 = 5'd0;
  logic [5:0] sop[2], sfn[2];
  logic [4:0] ss1[2], ss2[2], sd[2];
  logic [15:0] simm[2];

  assign ifc.in_valid = vin;
  assign ifc.ex_stall = stall;
  assign ifc.flush = fl;
  assign ifc.wb_valid = wbv;
  assign ifc.wb_reg0 = wr0;
  assign ifc.wb_reg1 = wr1;
  assign ifc.in_op0 = sop[0];
  assign ifc.in_op1 = sop[1];
  assign ifc.in_func0 = sfn[0];
  assign ifc.in_func1 = sfn[1];
  assign ifc.in_src1_0 = ss1[0];
  assign ifc.in_src1_1 = ss1[1];
  assign ifc.in_src2_0 = ss2[0];
  assign ifc.in_src2_1 = ss2[1];
  assign ifc.in_dest0 = sd[0];
  assign ifc.in_dest1 = sd[1];
  assign ifc.in_imm0 = simm[0];
  assign ifc.in_imm1 = simm[1];

  // reference model: pending-write set plus the expected contents of each lane
  bit [31:0] mb;
  bit ev[2];
  logic [5:0] eop[2], efn[2];
  logic [4:0] es1[2], es2[2], ed[2];
  logic [15:0] eimm[2];
  logic [1:0] acc_seen;
  int ncmp = 0, nerr = 0;

  typedef struct {
    bit legal, br, mem;
    int ra, rb, w;
  } cls_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [4:0] s1, s2, d);
    cls_t c;
    c.legal = 1; c.br = 0; c.mem = 0; c.ra = -1; c.rb = -1; c.w = -1;
    case (op)
      6'h00: begin c.ra = s1; c.rb = s2; c.w = d; end
      6'h23: begin c.ra = s1; c.w = d; c.mem = 1; end
      6'h08: begin c.ra = s1; c.w = d; end
      6'h2b: begin c.ra = s1; c.rb = s2; c.mem = 1; end
      6'h04, 6'h05: begin c.ra = s1; c.rb = s2; c.br = 1; end
      default: c.legal = 0;
    endcase
    if (c.ra == 0) c.ra = -1;
    if (c.rb == 0) c.rb = -1;
    if (c.w == 0) c.w = -1;
    return c;
  endfunction

  function automatic bit blocked(input cls_t c);
    return (c.ra >= 0 && mb[c.ra]) || (c.rb >= 0 && mb[c.rb]);
  endfunction

  task automatic slot(input int i, input logic [5:0] op, input logic [4:0] s1, s2, d);
    sop[i] = op; sfn[i] = 6'h20 + 6'(i); ss1[i] = s1; ss2[i] = s2; sd[i] = d;
    simm[i] = 16'h100 + 16'(i);
  endtask

  task automatic step();
    cls_t c0, c1, k;
    bit a0, a1;
    bit [31:0] nb;
    logic [5:0] gop, gfn;
    logic [4:0] gs1, gs2, gd;
    logic [15:0] gim;
    #1;
    c0 = classify(sop[0], ss1[0], ss2[0], sd[0]);
    c1 = classify(sop[1], ss1[1], ss2[1], sd[1]);
    a0 = rst_n && vin[0] && !stall && !fl && !blocked(c0);
    a1 = a0 && vin[1] && c1.legal && !blocked(c1) &&
         !(c0.w >= 0 && (c1.ra == c0.w || c1.rb == c0.w)) &&
         !(c1.w >= 0 && c1.w == c0.w) && !(c0.mem && c1.mem) && c0.legal && !c0.br;
    acc_seen = ifc.in_accept;
    chk("in_accept", ifc.in_accept, {a1, a0});
    nb = mb;
    if (wbv[0]) nb[wr0] = 0;
    if (wbv[1]) nb[wr1] = 0;
    if (fl)
      for (int i = 0; i < 2; i++)
        if (ev[i]) begin
          k = classify(eop[i], es1[i], es2[i], ed[i]);
          if (k.w >= 0) nb[k.w] = 0;
        end
    if (a0 && c0.w >= 0) nb[c0.w] = 1;
    if (a1 && c1.w >= 0) nb[c1.w] = 1;
    @(posedge clk);
    mb = nb;
    if (fl) begin
      ev[0] = 0; ev[1] = 0;
    end else if (!stall) begin
      ev[0] = a0; ev[1] = a1;
      for (int i = 0; i < 2; i++) begin
        eop[i] = sop[i]; efn[i] = sfn[i]; es1[i] = ss1[i]; es2[i] = ss2[i];
        ed[i] = sd[i]; eimm[i] = simm[i];
      end
    end
    #1;
    chk("iss_valid", ifc.iss_valid, {ev[1], ev[0]});
    chk("busy", ifc.busy, mb);
    for (int i = 0; i < 2; i++)
      if (ev[i]) begin
        gop = i == 0 ? ifc.iss_op0 : ifc.iss_op1;
        gfn = i == 0 ? ifc.iss_func0 : ifc.iss_func1;
        gs1 = i == 0 ? ifc.iss_src1_0 : ifc.iss_src1_1;
        gs2 = i == 0 ? ifc.iss_src2_0 : ifc.iss_src2_1;
        gd = i == 0 ? ifc.iss_dest0 : ifc.iss_dest1;
        gim = i == 0 ? ifc.iss_imm0 : ifc.iss_imm1;
        chk($sformatf("iss_fields%0d", i), {gop, gfn, gs1, gs2, gd, gim},
            {eop[i], efn[i], es1[i], es2[i], ed[i], eimm[i]});
      end
    wbv = 2'b00;
  endtask

  function automatic logic [4:0] pick_busy();
    for (int t = 0; t < 8; t++) begin
      int r = $urandom_range(1, 7);
      if (mb[r]) return 5'(r);
    end
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic drain();
    vin = 2'b00; stall = 0; fl = 0;
    for (int n = 0; n < 20 && mb != 0; n++) begin
      wbv = 2'b00;
      for (int r = 31; r > 0; r--)
        if (mb[r]) begin
          if (wbv[0]) begin wbv[1] = 1; wr1 = 5'(r); end
          else begin wbv[0] = 1; wr0 = 5'(r); end
        end
      step();
    end
    chk("drain_busy", ifc.busy, 0);
  endtask

  task automatic reset_model();
    mb = 0; ev[0] = 0; ev[1] = 0;
  endtask

  task automatic rand_cycle();
    logic [5:0] ops[8] = '{6'h00, 6'h00, 6'h23, 6'h08, 6'h2b, 6'h04, 6'h05, 6'h3f};
    logic [1:0] vs[4] = '{2'b00, 2'b01, 2'b11, 2'b11};
    vin = vs[$urandom_range(0, 3)];
    for (int i = 0; i < 2; i++) begin
      slot(i, ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      sfn[i] = 6'($urandom); simm[i] = 16'($urandom);
    end
    stall = $urandom_range(0, 99) < 15;
    fl = $urandom_range(0, 99) < 5;
    wbv = {1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 40)};
    wr0 = pick_busy();
    wr1 = pick_busy();
    step();
  endtask

  initial begin
    reset_model();
    slot(0, 6'h00, 5'd1, 5'd2, 5'd3);
    slot(1, 6'h00, 5'd4, 5'd5, 5'd6);
    #3;
    chk("rst_accept", ifc.in_accept, 0);
    chk("rst_iss_valid", ifc.iss_valid, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_fields", {ifc.iss_op0, ifc.iss_dest1, ifc.iss_imm0}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;

    step();
    chk("tp_pair_accept", acc_seen, 2'b11);
    chk("tp_pair_busy", {ifc.busy[6], ifc.busy[3]}, 2'b11);

    slot(0, 6'h08, 5'd1, 5'd0, 5'd7);
    slot(1, 6'h00, 5'd7, 5'd2, 5'd8);
    step();
    chk("tp_raw_accept", acc_seen, 2'b01);
    slot(0, 6'h00, 5'd7, 5'd2, 5'd8);
    vin = 2'b01;
    step();
    chk("tp_raw_stall", acc_seen, 2'b00);
    wbv = 2'b01; wr0 = 5'd7;
    step();
    chk("tp_wb_no_bypass", acc_seen, 2'b00);
    step();
    chk("tp_wb_unblock", acc_seen, 2'b01);
    drain();

    vin = 2'b11;
    slot(0, 6'h23, 5'd1, 5'd0, 5'd2);
    slot(1, 6'h2b, 5'd1, 5'd3, 5'd0);
    step();
    chk("tp_mem_port", acc_seen, 2'b01);
    drain();
    vin = 2'b11;
    slot(0, 6'h04, 5'd1, 5'd2, 5'd0);
    slot(1, 6'h00, 5'd5, 5'd6, 5'd4);
    step();
    chk("tp_branch", acc_seen, 2'b01);
    drain();

    vin = 2'b01;
    slot(0, 6'h00, 5'd1, 5'd2, 5'd0);
    step();
    chk("tp_r0_busy", ifc.busy, 0);
    slot(0, 6'h08, 5'd1, 5'd0, 5'd9);
    wbv = 2'b01; wr0 = 5'd9;
    step();
    chk("tp_set_wins", ifc.busy[9], 1);
    drain();

    vin = 2'b11;
    slot(0, 6'h00, 5'd1, 5'd2, 5'd10);
    slot(1, 6'h00, 5'd3, 5'd4, 5'd11);
    step();
    stall = 1;
    slot(0, 6'h00, 5'd1, 5'd2, 5'd12);
    slot(1, 6'h00, 5'd3, 5'd4, 5'd13);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("tp_stall_accept", acc_seen, 2'b00);
      chk("tp_stall_hold", {ifc.iss_valid, ifc.iss_dest0, ifc.iss_dest1}, {2'b11, 5'd10, 5'd11});
    end
    stall = 0;
    step();
    chk("tp_release", acc_seen, 2'b11);
    drain();

    vin = 2'b01;
    slot(0, 6'h08, 5'd1, 5'd0, 5'd5);
    step();
    stall = 1; fl = 1;
    step();
    chk("tp_flush_valid", ifc.iss_valid, 2'b00);
    chk("tp_flush_busy5", ifc.busy[5], 0);
    stall = 0; fl = 0;

    for (int n = 0; n < 3000; n++) rand_cycle();

    vin = 2'b11; stall = 0; fl = 0;
    slot(0, 6'h00, 5'd1, 5'd2, 5'd3);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_accept", ifc.in_accept, 0);
    chk("mid_rst_iss_valid", ifc.iss_valid, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_fields", {ifc.iss_op0, ifc.iss_src1_0, ifc.iss_imm1}, 0);
    reset_model();
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    for (int n = 0; n < 300; n++) rand_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue in-order scheduler between the instruction decoder and the two execute lanes of the superscalar MIPS pipeline. Each cycle it takes up to two decoded instructions (slot 0 older), checks them against a 32-entry register scoreboard and against each other, and issues zero, one or both into registered issue ports. It tracks pending register writes until writeback.

## Interface
- NREGS, 32, architectural register count; scoreboard width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  2  bit i: decoded slot i present; bit 1 only valid with bit 0
- in_op0 / in_op1  input  6  opcode per slot
- in_func0 / in_func1  input  6  function field per slot
- in_src1_0 / in_src1_1  input  5  first source register
- in_src2_0 / in_src2_1  input  5  second source register
- in_dest0 / in_dest1  input  5  destination register as decoded
- in_imm0 / in_imm1  input  16  immediate
- in_accept  output  2  combinational; bit i: slot i consumed this cycle; bit 1 implies bit 0
- ex_stall  input  1  execute stage holds; issue registers must not change
- flush  input  1  branch redirect; kill held and presented instructions
- wb_valid  input  2  writeback port i retires a register write
- wb_reg0 / wb_reg1  input  5  register written by writeback port i
- iss_valid  output  2  issue lane i holds a valid instruction
- iss_op0/1, iss_func0/1, iss_src1_0/1, iss_src2_0/1, iss_dest0/1, iss_imm0/1  output  6/6/5/5/5/16  registered copy of the issued slot
- busy  output  NREGS  scoreboard, bit r set while register r has a pending write

## Operation
- Classification by opcode: 0x00 R-type (reads src1, src2; writes dest); 0x23 LW, 0x08 ADDI (read src1; write dest); 0x2B SW, 0x04 BEQ, 0x05 BNE (read src1, src2; no write). Any other opcode is illegal: no reads, no write, issues alone in lane 0.
- A write to register 0 never sets a busy bit. A read of register 0 never blocks.
- Slot 0 issues when in_valid[0], no ex_stall, no flush, and no read register is busy.
- Slot 1 issues only when slot 0 issues in the same cycle and all of the following hold:
  - its read registers are not busy and are not slot 0's written register (RAW);
  - its written register differs from slot 0's (WAW);
  - slot 0 and slot 1 are not both memory ops (LW/SW), because there is one memory port;
  - slot 0 is not a branch or illegal.
- Issuing a writing instruction sets busy[dest] at the clock edge. wb_valid[i] clears busy[wb_reg_i]. If a set and a clear hit the same register in the same cycle, the set wins.
- Issue registers:
  - On ex_stall, all issue registers hold.
  - Otherwise iss_valid[i] equals in_accept[i], and fields load from slot i.
  - Fields of an invalid lane are don't-care but must not toggle scoreboard state.
- flush takes precedence over ex_stall:
  - in_accept is 0 and iss_valid goes to 0 next cycle.
  - Busy bits set by instructions killed in issue registers (iss_valid=1 at the flush edge) are cleared, unless a same-cycle issue sets them. It cannot, because flush blocks issue.
  - Busy bits of instructions already past issue remain.

## Timing
- Reset (asynchronous on rst_n low): iss_valid=0, all iss_* fields 0, busy=0. in_accept reads 0 while rst_n is low.
- Latency: accepted instruction visible on iss_* one cycle after in_accept. Busy visible the same following cycle.
- in_accept is a pure function of the current inputs and busy. Fetch must re-present an unaccepted slot 1 as slot 0 next cycle.
- A writeback in cycle n unblocks a dependent instruction in cycle n+1, with no bypass of the clear into in_accept.
- Sustained throughput is 2 per cycle for independent non-memory pairs.

## Test plan
- Reset then two independent R-types: ADD r3,r1,r2 / SUB r6,r4,r5 -> in_accept=11, next cycle iss_valid=11, busy bits 3 and 6 set.
- RAW within pair: ADDI r7,r1,5 / ADD r8,r7,r2 -> in_accept=01. Next cycle, ADD re-presented in slot 0 stalls until wb_valid[0] with wb_reg0=7. It is accepted in the cycle after the writeback.
- Structural and branch limits: LW r2,0(r1) / SW r3,4(r1) -> in_accept=01. BEQ r1,r2 / ADD r4,r5,r6 -> in_accept=01.
- Register 0 and set/clear collision: ADD r0,r1,r2 leaves busy=0. Issue ADDI r9 in the same cycle as wb_reg0=9 -> busy[9] stays 1.
- ex_stall high 3 cycles with valid issue lanes -> iss_* stable and in_accept=00. Release -> normal issue resumes.
- flush while ex_stall holds ADDI r5 in lane 0 -> iss_valid=00 next cycle and busy[5] cleared. Assert rst_n low mid-stream -> all outputs 0 immediately.
